// File: rtl/kpn_pkg.sv
// Shared definitions for KPN channel blocks: default widths, token type and
// the occupancy encoding of the reader's two-entry buffer.
package kpn_pkg;

  localparam int KPN_BITS_NUMBER = 16;
  localparam int KPN_COUNT_BITS  = 16;

  typedef logic [KPN_BITS_NUMBER-1:0] kpn_token_t;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_state_t;

endpackage

// File: rtl/kpn_skid_buffer.sv
// Two-entry ordered token buffer. Entry e0 is always the head; a push lands
// behind whatever remains after a same-edge pop.
module kpn_skid_buffer
  import kpn_pkg::*;
#(
  parameter int W = KPN_BITS_NUMBER
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head_data,
  output logic         head_valid,
  output occ_state_t   state_dbg
);

  occ_state_t   state;
  logic [W-1:0] e0;
  logic [W-1:0] e1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= OCC_EMPTY;
      e0    <= '0;
      e1    <= '0;
    end else begin
      case (state)
        OCC_EMPTY: begin
          if (push) begin
            e0    <= push_data;
            state <= OCC_ONE;
          end
        end
        OCC_ONE: begin
          // Capture and pop together: the new token replaces the head.
          if (push && pop) begin
            e0 <= push_data;
          end else if (push) begin
            e1    <= push_data;
            state <= OCC_FULL;
          end else if (pop) begin
            state <= OCC_EMPTY;
          end
        end
        OCC_FULL: begin
          if (pop) begin
            e0    <= e1;
            state <= OCC_ONE;
          end
        end
        default: state <= OCC_EMPTY;
      endcase
    end
  end

  assign head_data  = e0;
  assign head_valid = (state != OCC_EMPTY);
  assign state_dbg  = state;

  // The issue rule upstream guarantees a capture never meets a full buffer.
  a_no_push_when_full: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && state == OCC_FULL));

endmodule

// File: rtl/kpn_fifo_reader.sv
// Kahn blocking-read port: issues channel FIFO reads, hides the one-cycle read
// latency in a two-entry buffer, and keeps token/stall profiling counters.
module kpn_fifo_reader
  import kpn_pkg::*;
#(
  parameter int BITS_NUMBER = KPN_BITS_NUMBER,
  parameter int COUNT_BITS  = KPN_COUNT_BITS
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   fifo_empty,
  input  logic [BITS_NUMBER-1:0] fifo_data,
  output logic                   fifo_rd,
  output logic [BITS_NUMBER-1:0] out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [COUNT_BITS-1:0]  tokens_read,
  output logic [COUNT_BITS-1:0]  stall_cycles
);

  // Handshake: a token transfers on every rising edge where out_valid and
  // out_ready are both 1; out_data/out_valid hold steady while out_ready is 0.
  logic       inflight;
  logic       pop;
  logic [2:0] level;
  occ_state_t occ_state;

  assign pop = out_valid & out_ready;

  // Tokens that will be held after this edge; a read is safe while below two.
  assign level   = {1'b0, occ_state} + {2'b00, inflight} - {2'b00, pop};
  assign fifo_rd = rst_n & ~fifo_empty & (level < 3'd2);

  kpn_skid_buffer #(
    .W (BITS_NUMBER)
  ) u_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (inflight),
    .push_data  (fifo_data),
    .pop        (pop),
    .head_data  (out_data),
    .head_valid (out_valid),
    .state_dbg  (occ_state)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight     <= 1'b0;
      tokens_read  <= '0;
      stall_cycles <= '0;
    end else begin
      inflight <= fifo_rd;
      if (pop) begin
        tokens_read <= tokens_read + COUNT_BITS'(1);
      end
      if (out_ready && !out_valid && (stall_cycles != '1)) begin
        stall_cycles <= stall_cycles + COUNT_BITS'(1);
      end
    end
  end

endmodule

// File: tb/tb_kpn_fifo_reader.sv
// Bench for kpn_fifo_reader: a behavioural channel FIFO, a token-queue model of
// the reader checked every cycle, and directed scenarios with literal checks.
module tb_kpn_fifo_reader;
  import kpn_pkg::*;

  localparam int W = 16;
  localparam int C = 16;

  logic         clk;
  logic         rst_n;
  logic         fifo_empty;
  logic [W-1:0] fifo_data;
  logic         fifo_rd;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         out_ready;
  logic [C-1:0] tokens_read;
  logic [C-1:0] stall_cycles;

  kpn_fifo_reader #(
    .BITS_NUMBER (W),
    .COUNT_BITS  (C)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .fifo_empty   (fifo_empty),
    .fifo_data    (fifo_data),
    .fifo_rd      (fifo_rd),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .tokens_read  (tokens_read),
    .stall_cycles (stall_cycles)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- channel FIFO (behavioural) ----------------
  kpn_token_t pend_q[$];
  kpn_token_t chan_q[$];
  logic       rd_s = 1'b0;

  // ---------------- reader model ----------------
  logic [W-1:0] exp_q[$];
  logic         m_inflight = 1'b0;
  logic [W-1:0] m_inflight_tok = '0;
  logic [C-1:0] m_tok = '0;
  logic [C-1:0] m_stall = '0;
  logic         m_pop = 1'b0;
  logic         exp_rd = 1'b0;
  int           lvl;

  logic [W-1:0] deliv_q[$];
  int           rd_count = 0;

  // Compare process: outputs are stable at the falling edge.
  always @(negedge clk) begin
    rd_s = fifo_rd;
    if (chk_en) begin
      if (!rst_n) begin
        m_pop  = 1'b0;
        exp_rd = 1'b0;
        check("rst_fifo_rd", fifo_rd, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_tokens", tokens_read, 0);
        check("rst_stall", stall_cycles, 0);
      end else begin
        m_pop  = (exp_q.size() != 0) && out_ready;
        lvl    = exp_q.size() + (m_inflight ? 1 : 0) - (m_pop ? 1 : 0);
        exp_rd = (chan_q.size() != 0) && (lvl < 2);
        check("occ_le_2", (lvl <= 2) ? 1 : 0, 1);
        check("fifo_rd", fifo_rd, exp_rd);
        check("out_valid", out_valid, (exp_q.size() != 0) ? 1 : 0);
        if (exp_q.size() != 0) check("out_data", out_data, exp_q[0]);
        check("tokens_read", tokens_read, m_tok);
        check("stall_cycles", stall_cycles, m_stall);
        if (out_valid && out_ready) deliv_q.push_back(out_data);
        if (fifo_rd) rd_count++;
      end
    end
  end

  // Model update and channel FIFO advance on the rising edge.
  always @(posedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      m_inflight = 1'b0;
      m_tok      = '0;
      m_stall    = '0;
    end else begin
      if (out_ready && exp_q.size() == 0 && m_stall != '1) m_stall = m_stall + 1'b1;
      if (m_pop) begin
        void'(exp_q.pop_front());
        m_tok = m_tok + 1'b1;
      end
      if (m_inflight) exp_q.push_back(m_inflight_tok);
      m_inflight = exp_rd;
      if (exp_rd && chan_q.size() != 0) m_inflight_tok = chan_q[0];
    end
    if (rd_s && chan_q.size() != 0) fifo_data <= chan_q.pop_front();
    while (pend_q.size() != 0) chan_q.push_back(pend_q.pop_front());
    fifo_empty <= (chan_q.size() == 0);
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_tokens(input logic [W-1:0] base, input int n);
    for (int i = 0; i < n; i++) pend_q.push_back(base + W'(i));
  endtask

  task automatic check_deliv(input string name, input logic [W-1:0] base, input int n);
    check({name, "_count"}, deliv_q.size(), n);
    for (int i = 0; i < n && i < deliv_q.size(); i++) check(name, deliv_q[i], base + W'(i));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n      = 1'b1;
    out_ready  = 1'b0;
    fifo_empty = 1'b1;
    fifo_data  = '0;
    #2 rst_n   = 1'b0;
    #1 chk_en  = 1'b1;

    // Reset, then blocking read on an empty channel.
    tick(3);
    check("reset_valid", out_valid, 0);
    check("reset_tokens", tokens_read, 0);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    tick(10);
    check("block_valid", out_valid, 0);
    check("block_stall10", stall_cycles, 10);
    push_tokens(16'hBEEF, 1);
    for (int i = 0; i < 10; i++) begin
      if (out_valid) break;
      tick();
    end
    check("beef_valid", out_valid, 1);
    check("beef_data", out_data, 16'hBEEF);
    out_ready = 1'b0;
    tick(2);
    check("beef_stall_held", stall_cycles, 13);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    tick();
    check("beef_tokens", tokens_read, 1);
    check("beef_stall_final", stall_cycles, 13);

    // Stream of 8 preloaded tokens, reset held with a non-empty channel.
    rst_n = 1'b0;
    push_tokens(16'h0001, 8);
    tick(2);
    check("rst_nonempty_rd", fifo_rd, 0);
    check("rst_nonempty_tok", tokens_read, 0);
    deliv_q.delete();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    tick();
    check("stream_lat1", out_valid, 0);
    tick();
    check("stream_lat2", out_valid, 1);
    check("stream_first", out_data, 16'h0001);
    tick(7);
    check("stream_tok7", tokens_read, 7);
    tick();
    check("stream_tok8", tokens_read, 8);
    check_deliv("stream", 16'h0001, 8);

    // Backpressure: only two reads may be outstanding.
    out_ready = 1'b0;
    deliv_q.delete();
    rd_count  = 0;
    push_tokens(16'h0011, 5);
    tick(8);
    check("bp_rd_pulses", rd_count, 2);
    check("bp_valid", out_valid, 1);
    check("bp_head", out_data, 16'h0011);
    out_ready = 1'b1;
    tick(10);
    check("bp_rd_total", rd_count, 5);
    check_deliv("bp", 16'h0011, 5);

    // Alternating consumer readiness with a continuous supply.
    deliv_q.delete();
    push_tokens(16'h0100, 12);
    for (int i = 0; i < 40; i++) begin
      out_ready = ~out_ready;
      tick();
    end
    out_ready = 1'b1;
    tick(4);
    check_deliv("alt", 16'h0100, 12);
    check("alt_tokens", tokens_read, 25);

    // Reset mid-stream with a read in flight.
    deliv_q.delete();
    push_tokens(16'h0200, 10);
    tick(4);
    check("mid_first", (deliv_q.size() > 0) ? deliv_q[0] : 16'hFFFF, 16'h0200);
    rst_n = 1'b0;
    #1;
    check("mid_rst_rd", fifo_rd, 0);
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_data", out_data, 0);
    check("mid_rst_tokens", tokens_read, 0);
    tick(2);
    deliv_q.delete();
    rst_n = 1'b1;
    tick(15);
    check_deliv("mid_after", 16'h0203, 7);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/kpn_fifo_reader.md
# kpn_fifo_reader

Consumer-side read port for a KPN channel FIFO: implements Kahn blocking-read semantics between the channel FIFO (single-cycle registered read on `rd`) and a downstream process node using a valid/ready handshake. It issues FIFO read strobes, absorbs the one-cycle FIFO read latency in a 2-entry buffer so the consumer sees full throughput, and exposes token and stall counters for network profiling.

## Interface
- `BITS_NUMBER`, 16, token data width; must match the channel FIFO.
- `COUNT_BITS`, 16, width of `tokens_read` and `stall_cycles`.

Ports:
- `clk`  in  1  single clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `fifo_empty`  in  1  channel FIFO empty flag.
- `fifo_data`  in  BITS_NUMBER  FIFO read data; valid in the cycle after `fifo_rd` was high.
- `fifo_rd`  out  1  FIFO read strobe; one token per high cycle.
- `out_data`  out  BITS_NUMBER  token to consumer (head of buffer).
- `out_valid`  out  1  `out_data` holds a token.
- `out_ready`  in  1  consumer accepts token.
- `tokens_read`  out  COUNT_BITS  tokens delivered to consumer, wraps modulo 2^COUNT_BITS.
- `stall_cycles`  out  COUNT_BITS  cycles with `out_ready`=1 and `out_valid`=0; saturates at all-ones.

## Operation
- State: `occ` (0..2 buffered tokens), `inflight` (1 = read issued last cycle, data arrives this cycle), 2-entry buffer in FIFO order.
- Pop: `pop = out_valid & out_ready`; removes head, next entry becomes head same edge.
- Read issue (combinational): `fifo_rd = rst_n & ~fifo_empty & (occ + inflight - pop < 2)`.
- `inflight` next = `fifo_rd`. When `inflight`=1, `fifo_data` is written to buffer at that edge (behind any remaining entry after pop).
- Occupancy states: EMPTY (occ 0), ONE (occ 1), FULL (occ 2); transitions per edge `occ_next = occ + inflight - pop`; never exceeds 2 by construction.
- `out_valid = (occ != 0)`; registered state, no combinational path from `fifo_data` to `out_data`.
- Blocking read: with `fifo_empty`=1 and occ=0, `out_valid` stays 0 indefinitely; no data invented, no timeout.
- `tokens_read` += 1 on each pop; `stall_cycles` += 1 each cycle `out_ready & ~out_valid`, holding at max.
- Simultaneous capture + pop at occ=1: head popped, captured token becomes head, occ stays 1.
- Simultaneous capture + pop at occ=2 cannot occur (issue rule prevents it).

## Timing
- Reset (async assert, sync-to-clk deassert usage assumed by system): `occ`=0, `inflight`=0, `out_valid`=0, `out_data`=0, `fifo_rd`=0, counters=0.
- Latency: `fifo_rd` high at edge N → token captured at edge N+1 → `out_valid` high after edge N+1 (2 cycles from FIFO non-empty to consumer-visible).
- Throughput: 1 token/cycle sustained with `out_ready` held high and FIFO non-empty.
- `out_data`/`out_valid` stable while `out_valid & ~out_ready`.
- Reset mid-operation: in-flight and buffered tokens are discarded; the FIFO pointer has already advanced, so those tokens are lost — system-level reset must reset the channel FIFO together with this block.
- `fifo_rd` depends combinationally on `fifo_empty` and `out_ready`; no other combinational input-to-output paths.

## Structure
- Shared package `kpn_pkg`: default `BITS_NUMBER`, `COUNT_BITS`, token type `kpn_token_t`.
- Sub-module `kpn_skid_buffer`: 2-entry ordered buffer with push/pop/occ; reader top holds issue logic, `inflight`, counters.

## Test plan
- Reset: hold `rst_n`=0 with `fifo_empty`=0 → `fifo_rd`=0, `out_valid`=0, counters 0.
- Stream: FIFO preloaded 0x0001..0x0008, `out_ready`=1 → first `out_valid` 2 cycles after release, 8 tokens in order on consecutive cycles, `tokens_read`=8.
- Backpressure: `out_ready`=0 with FIFO holding 5 tokens → exactly 2 `fifo_rd` pulses, `out_data`=first token held; release → remaining 3 read, all 5 delivered in order.
- Blocking read: FIFO empty, `out_ready`=1 for 10 cycles → `out_valid`=0, `stall_cycles`=10; write 0xBEEF → delivered, stall count stops.
- Alternating `out_ready` 1/0 with continuous FIFO data → no loss/duplication, occ never >2 (assertion), `tokens_read` equals pops.
- Reset mid-stream with `inflight`=1 → outputs return to reset values immediately; after release no stale token appears.
